// File: rtl/xpb_ctrl_pkg.sv
// Shared defaults, state encoding and width helper for the xpb lookup sequencer.
package xpb_ctrl_pkg;

  localparam int XPB_DIGIT_BITS = 5;
  localparam int XPB_NUM_DIGITS = 8;
  localparam int XPB_WORD_BITS  = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } xpb_state_e;

  // Adding num_digits values of word_bits each needs clog2(num_digits) carry bits.
  function automatic int acc_bits(input int word_bits, input int num_digits);
    return word_bits + $clog2(num_digits);
  endfunction

endpackage

// File: rtl/xpb_digit_pick.sv
// Priority finder: lowest set bit of the remaining-digit mask, plus a none-left flag.
module xpb_digit_pick
  import xpb_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = XPB_NUM_DIGITS,
  parameter int SEL_BITS   = $clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SEL_BITS-1:0]   idx,
  output logic                  none
);

  always_comb begin
    idx  = '0;
    none = 1'b1;
    // Scan downwards so the lowest set position is the last one written.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx  = SEL_BITS'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/xpb_lut_sequencer.sv
// Slices squaring overflow bits into digits, issues them to the xpb lookup bank and sums the returns.
// Optional macro XPB_ZERO_SKIP_EN: issue only nonzero digits (variable latency).
module xpb_lut_sequencer
  import xpb_ctrl_pkg::*;
#(
  parameter int DIGIT_BITS  = XPB_DIGIT_BITS,
  parameter int NUM_DIGITS  = XPB_NUM_DIGITS,
  parameter int WORD_BITS   = XPB_WORD_BITS,
  parameter int LUT_LATENCY = 1,
  parameter int SEL_BITS    = $clog2(NUM_DIGITS),
  parameter int ACC_BITS    = acc_bits(WORD_BITS, NUM_DIGITS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] upper_in,
  output logic                             busy,
  output logic                             lut_en,
  output logic [SEL_BITS-1:0]              lut_sel,
  output logic [DIGIT_BITS-1:0]            lut_addr,
  input  logic [WORD_BITS-1:0]             lut_data,
  output logic [ACC_BITS-1:0]              acc_out,
  output logic                             done
);

  xpb_state_e state, state_nxt;

  logic [NUM_DIGITS*DIGIT_BITS-1:0] upper_q;
  logic [LUT_LATENCY-1:0]           vld_p;
  logic [LUT_LATENCY-1:0]           vld_p_nxt;
  logic [SEL_BITS-1:0]              cur_sel;
  logic                             last_issue;
  logic                             start_empty;
  logic                             accept;

  assign accept = start && ((state == IDLE) || (state == FIN));

`ifdef XPB_ZERO_SKIP_EN
  logic [NUM_DIGITS-1:0] remain_q;
  logic [NUM_DIGITS-1:0] remain_after;
  logic [NUM_DIGITS-1:0] nz_in;
  logic [NUM_DIGITS-1:0] pick_mask;
  logic [SEL_BITS-1:0]   pick_idx;
  logic                  pick_none;

  always_comb begin
    nz_in = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nz_in[i] = |upper_in[i*DIGIT_BITS +: DIGIT_BITS];
    end
  end

  // Outside ISSUE the picker looks at the incoming request so an all-zero start can jump to FIN.
  assign pick_mask    = (state == ISSUE) ? remain_q : nz_in;
  assign remain_after = remain_q & ~(NUM_DIGITS'(1) << pick_idx);
  assign cur_sel      = pick_idx;
  assign last_issue   = (remain_after == '0);
  assign start_empty  = pick_none;

  xpb_digit_pick #(
    .NUM_DIGITS (NUM_DIGITS),
    .SEL_BITS   (SEL_BITS)
  ) u_pick (
    .mask (pick_mask),
    .idx  (pick_idx),
    .none (pick_none)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remain_q <= '0;
    end else if (accept) begin
      remain_q <= nz_in;
    end else if (state == ISSUE) begin
      remain_q <= remain_after;
    end
  end
`else
  logic [SEL_BITS-1:0] idx_q;

  assign cur_sel     = idx_q;
  assign last_issue  = (idx_q == SEL_BITS'(NUM_DIGITS - 1));
  assign start_empty = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= '0;
    end else if (state == ISSUE) begin
      idx_q <= idx_q + 1'b1;
    end
  end
`endif

  // Issue stage: outputs decoded from the state and current digit index
  always_comb begin
    lut_en   = 1'b0;
    lut_sel  = '0;
    lut_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ISSUE: begin
        lut_en   = 1'b1;
        lut_sel  = cur_sel;
        lut_addr = upper_q[cur_sel*DIGIT_BITS +: DIGIT_BITS];
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    vld_p_nxt    = '0;
    vld_p_nxt[0] = lut_en;
    for (int i = 1; i < LUT_LATENCY; i++) begin
      vld_p_nxt[i] = vld_p[i-1];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = start_empty ? FIN : ISSUE;
      end
      ISSUE: begin
        if (last_issue) state_nxt = DRAIN;
      end
      // Leave DRAIN on the edge that retires the final return.
      DRAIN: begin
        if (vld_p_nxt == '0) state_nxt = FIN;
      end
      FIN: begin
        if (start) state_nxt = start_empty ? FIN : ISSUE;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      upper_q <= upper_in;
    end
  end

  // Return stage: valid pipe tracks lookups in flight, accumulate on its output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld_p   <= '0;
      acc_out <= '0;
    end else begin
      state <= state_nxt;
      vld_p <= vld_p_nxt;
      if (accept) begin
        acc_out <= '0;
      end else if (vld_p[LUT_LATENCY-1]) begin
        acc_out <= acc_out + ACC_BITS'(lut_data);
      end
    end
  end

endmodule
